pipe_interlock: RTL and testbench
=================================

// Module: pipe_interlock
// PURPOSE
//   Pipeline interlock controller for the 5-stage core. Covers hazards that
//   EX/MEM and MEM/WB forwarding cannot resolve:
//     - load-use: one-cycle stall plus bubble
//     - taken branch/jump resolved in EX: flush of the wrong-path instructions
//     - data-memory wait states: full-pipeline freeze with handshake
//   Drives per-stage stall, bubble and flush strobes. Also keeps saturating
//   performance counters and a sticky memory-timeout error.
// PARAMETERS
//   CNT_W    16    width of the stall and flush performance counters
//   TIMEOUT  255   maximum consecutive memory-wait cycles before mem_timeout
//   TO_W     8     width of the wait-cycle counter; must hold TIMEOUT
// PORTS
//   clk             in   1      core clock; all state updates on the rising edge
//   rst             in   1      synchronous reset, active-high
//   rs1_IfId        in   5      rs1 of the instruction in ID
//   rs2_IfId        in   5      rs2 of the instruction in ID
//   use_rs1_IfId    in   1      the ID instruction actually reads rs1
//   use_rs2_IfId    in   1      the ID instruction actually reads rs2
//   rd_IdEx         in   5      destination of the instruction in EX
//   mem_read_IdEx   in   1      the instruction in EX is a load
//   branch_taken_Ex in   1      EX redirects the PC this cycle
//   dmem_req_ExMem  in   1      the instruction in MEM issues a data-memory access
//   dmem_ready      in   1      data memory completes the access this cycle
//   stall_pc        out  1      hold the PC
//   stall_IfId      out  1      hold the IF/ID register
//   stall_IdEx      out  1      hold the ID/EX register
//   stall_ExMem     out  1      hold the EX/MEM register
//   bubble_IdEx     out  1      load a NOP into ID/EX (control bits cleared)
//   bubble_MemWb    out  1      load a NOP into MEM/WB
//   flush_IfId      out  1      replace IF/ID with a NOP
//   mem_timeout     out  1      sticky error: memory wait exceeded TIMEOUT cycles
//   stall_cycles    out  CNT_W  saturating count of cycles with stall_pc=1
//   flush_count     out  CNT_W  saturating count of branch flushes
// BEHAVIOUR
//   Hazard conditions, all evaluated combinationally in the current cycle:
//   - W (mem wait)  = dmem_req_ExMem & ~dmem_ready.
//   - B (branch)    = branch_taken_Ex.
//   - L (load-use)  = mem_read_IdEx & (rd_IdEx != 0) &
//                     ((use_rs1_IfId & rs1_IfId == rd_IdEx) |
//                      (use_rs2_IfId & rs2_IfId == rd_IdEx)).
//   Priority is W > B > L. Outputs are combinational from the state and the
//   inputs, so they take effect in the same cycle (zero latency).
//   - W: stall_pc = stall_IfId = stall_IdEx = stall_ExMem = 1, bubble_MemWb = 1.
//     B and L are masked. The EX/ID registers are held, so B and L are
//     re-evaluated on the cycle after dmem_ready.
//   - B (no W): flush_IfId = 1, bubble_IdEx = 1. L is ignored because the
//     instruction in ID is squashed.
//   - L (no W, no B): stall_pc = stall_IfId = 1, bubble_IdEx = 1 for exactly
//     one cycle. The next cycle the load is in MEM, L deasserts, and MEM/WB
//     forwarding supplies the value.
//   - No hazard: all strobes are 0.
//   State machine: RUN, MEM_WAIT, ERROR.
//   - RUN -> MEM_WAIT when W. MEM_WAIT -> RUN on the cycle dmem_ready=1.
//   - The wait counter clears on entry to MEM_WAIT and increments each
//     MEM_WAIT cycle.
//   - MEM_WAIT -> ERROR when the counter reaches TIMEOUT with dmem_ready still
//     low. mem_timeout=1 from the next cycle.
//   - ERROR keeps the W freeze asserted and holds mem_timeout until rst. It
//     exits to RUN only on rst.
//   - dmem_ready=1 in the same cycle as the timeout compare: the request
//     completes and the next state is RUN.
//   Counters:
//   - stall_cycles increments on every cycle with stall_pc=1.
//   - flush_count increments on every cycle with flush_IfId=1.
//   - Both saturate at all-ones; no wrap-around.
//   Reset:
//   - rst=1 forces the state to RUN and clears the wait counter, the
//     performance counters and mem_timeout on the next edge. This applies
//     mid-wait and in ERROR.
//   - While rst=1, every strobe output is forced to 0 regardless of inputs.
// TESTING
//   1. Load x5 in EX; ID instruction reads rs1=x5 (use_rs1=1) -> stall_pc,
//      stall_IfId, bubble_IdEx high for 1 cycle; stall_cycles=1.
//   2. Load with rd=x0, and separately rs2=x5 with use_rs2=0 -> no stall in
//      either case.
//   3. branch_taken_Ex=1 together with a load-use match -> flush_IfId=1,
//      bubble_IdEx=1, stall_pc=0; flush_count=1.
//   4. dmem_req=1, dmem_ready low for 3 cycles with branch_taken=1 ->
//      4-stage freeze for 3 cycles with no flush; flush fires on the cycle
//      after dmem_ready; stall_cycles=3.
//   5. dmem_ready held low for TIMEOUT+2 cycles -> mem_timeout=1, freeze
//      held; rst pulse -> mem_timeout=0, state RUN, counters 0.
//   6. Force stall_cycles to all-ones, then hold a stall -> value stays at
//      all-ones.

Source files
------------

// File: rtl/pipe_interlock.sv
// Pipeline interlock controller: load-use stall, branch flush and data-memory
// wait freeze with a sticky timeout error and saturating performance counters.
//
// state    | meaning
// RUN      | normal operation, hazards resolved combinationally
// MEM_WAIT | data-memory access outstanding, wait cycles being counted
// ERROR    | wait exceeded TIMEOUT; pipeline frozen until rst
module pipe_interlock #(
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 255,
  parameter int TO_W    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       rs1_IfId,
  input  logic [4:0]       rs2_IfId,
  input  logic             use_rs1_IfId,
  input  logic             use_rs2_IfId,
  input  logic [4:0]       rd_IdEx,
  input  logic             mem_read_IdEx,
  input  logic             branch_taken_Ex,
  input  logic             dmem_req_ExMem,
  input  logic             dmem_ready,
  output logic             stall_pc,
  output logic             stall_IfId,
  output logic             stall_IdEx,
  output logic             stall_ExMem,
  output logic             bubble_IdEx,
  output logic             bubble_MemWb,
  output logic             flush_IfId,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count
);

  typedef enum logic [1:0] {RUN, MEM_WAIT, ERROR} state_t;

  state_t           state_q, state_d;
  logic [TO_W-1:0]  wait_cnt_q, wait_cnt_d;
  logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;
  logic [CNT_W-1:0] flush_count_q, flush_count_d;

  logic haz_w, haz_b, haz_l;
  logic freeze, do_flush, do_lu;

  assign haz_w = dmem_req_ExMem & ~dmem_ready;
  assign haz_b = branch_taken_Ex;
  assign haz_l = mem_read_IdEx & (rd_IdEx != 5'd0) &
                 ((use_rs1_IfId & (rs1_IfId == rd_IdEx)) |
                  (use_rs2_IfId & (rs2_IfId == rd_IdEx)));

  // ERROR freezes unconditionally; reset masks every strobe.
  assign freeze   = ~rst & (haz_w | (state_q == ERROR));
  assign do_flush = ~rst & ~freeze & haz_b;
  assign do_lu    = ~rst & ~freeze & ~haz_b & haz_l;

  assign stall_pc     = freeze | do_lu;
  assign stall_IfId   = freeze | do_lu;
  assign stall_IdEx   = freeze;
  assign stall_ExMem  = freeze;
  assign bubble_MemWb = freeze;
  assign bubble_IdEx  = do_flush | do_lu;
  assign flush_IfId   = do_flush;
  assign mem_timeout  = (state_q == ERROR);
  assign stall_cycles = stall_cycles_q;
  assign flush_count  = flush_count_q;

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    case (state_q)
      RUN: begin
        if (haz_w) begin
          state_d    = MEM_WAIT;
          wait_cnt_d = '0;
        end
      end
      MEM_WAIT: begin
        if (!haz_w) begin
          state_d = RUN;
        end else if (wait_cnt_q == TO_W'(TIMEOUT)) begin
          state_d = ERROR;
        end else begin
          wait_cnt_d = wait_cnt_q + TO_W'(1);
        end
      end
      ERROR:   state_d = ERROR;
      default: state_d = RUN;
    endcase
  end

  always_comb begin
    stall_cycles_d = stall_cycles_q;
    flush_count_d  = flush_count_q;
    if (stall_pc && (stall_cycles_q != '1))
      stall_cycles_d = stall_cycles_q + CNT_W'(1);
    if (flush_IfId && (flush_count_q != '1))
      flush_count_d = flush_count_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= RUN;
      wait_cnt_q     <= '0;
      stall_cycles_q <= '0;
      flush_count_q  <= '0;
    end else begin
      state_q        <= state_d;
      wait_cnt_q     <= wait_cnt_d;
      stall_cycles_q <= stall_cycles_d;
      flush_count_q  <= flush_count_d;
    end
  end

endmodule

// File: tb/tb_pipe_interlock.sv
// Directed bench for pipe_interlock: hazard priority, wait freeze, timeout,
// counter saturation and reset behaviour with hand-computed expectations.
module tb_pipe_interlock;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  rs1_IfId, rs2_IfId, rd_IdEx;
  logic        use_rs1_IfId, use_rs2_IfId, mem_read_IdEx;
  logic        branch_taken_Ex, dmem_req_ExMem, dmem_ready;
  logic        stall_pc, stall_IfId, stall_IdEx, stall_ExMem;
  logic        bubble_IdEx, bubble_MemWb, flush_IfId, mem_timeout;
  logic [15:0] stall_cycles, flush_count;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pipe_interlock dut (
    .clk(clk), .rst(rst),
    .rs1_IfId(rs1_IfId), .rs2_IfId(rs2_IfId),
    .use_rs1_IfId(use_rs1_IfId), .use_rs2_IfId(use_rs2_IfId),
    .rd_IdEx(rd_IdEx), .mem_read_IdEx(mem_read_IdEx),
    .branch_taken_Ex(branch_taken_Ex), .dmem_req_ExMem(dmem_req_ExMem),
    .dmem_ready(dmem_ready),
    .stall_pc(stall_pc), .stall_IfId(stall_IfId), .stall_IdEx(stall_IdEx),
    .stall_ExMem(stall_ExMem), .bubble_IdEx(bubble_IdEx),
    .bubble_MemWb(bubble_MemWb), .flush_IfId(flush_IfId),
    .mem_timeout(mem_timeout), .stall_cycles(stall_cycles),
    .flush_count(flush_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // packs {stall_pc, stall_IfId, stall_IdEx, stall_ExMem, bubble_IdEx, bubble_MemWb, flush_IfId}
  function automatic logic [6:0] strobes();
    return {stall_pc, stall_IfId, stall_IdEx, stall_ExMem,
            bubble_IdEx, bubble_MemWb, flush_IfId};
  endfunction

  task automatic idle();
    rs1_IfId = 0; rs2_IfId = 0; rd_IdEx = 0;
    use_rs1_IfId = 0; use_rs2_IfId = 0; mem_read_IdEx = 0;
    branch_taken_Ex = 0; dmem_req_ExMem = 0; dmem_ready = 0;
  endtask

  // advance one clock; inputs change 1 time unit after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  initial begin
    rst = 1'b1;
    idle();
    tick(); tick();

    // reset masks strobes even with a live wait and branch
    dmem_req_ExMem = 1; branch_taken_Ex = 1; settle();
    chk("rst_strobes", 32'(strobes()), 32'h0);
    tick();
    rst = 1'b0; idle(); settle();
    chk("reset_idle_strobes", 32'(strobes()), 32'h0);
    chk("reset_stall_cnt", 32'(stall_cycles), 32'd0);
    chk("reset_flush_cnt", 32'(flush_count), 32'd0);
    chk("reset_timeout", 32'(mem_timeout), 32'd0);

    // 1: load-use on rs1
    mem_read_IdEx = 1; rd_IdEx = 5; rs1_IfId = 5; use_rs1_IfId = 1; settle();
    chk("lu_rs1_strobes", 32'(strobes()), 32'b1100100);
    tick(); idle(); settle();
    chk("lu_released", 32'(strobes()), 32'h0);
    chk("lu_stall_cnt", 32'(stall_cycles), 32'd1);

    // 2: rd=x0 and unused rs2 never stall; used rs2 does
    mem_read_IdEx = 1; rd_IdEx = 0; rs1_IfId = 0; use_rs1_IfId = 1; settle();
    chk("lu_x0", 32'(strobes()), 32'h0);
    idle(); mem_read_IdEx = 1; rd_IdEx = 5; rs2_IfId = 5; use_rs2_IfId = 0; settle();
    chk("lu_rs2_unused", 32'(strobes()), 32'h0);
    use_rs2_IfId = 1; settle();
    chk("lu_rs2_used", 32'(strobes()), 32'b1100100);
    tick(); idle(); settle();
    chk("lu_rs2_stall_cnt", 32'(stall_cycles), 32'd2);

    // 3: branch beats load-use
    mem_read_IdEx = 1; rd_IdEx = 7; rs1_IfId = 7; use_rs1_IfId = 1;
    branch_taken_Ex = 1; settle();
    chk("br_over_lu", 32'(strobes()), 32'b0000101);
    tick(); idle(); settle();
    chk("br_flush_cnt", 32'(flush_count), 32'd1);
    chk("br_stall_cnt", 32'(stall_cycles), 32'd2);

    // 4: memory wait masks branch for 3 cycles, flush on ready cycle
    for (int i = 0; i < 3; i++) begin
      dmem_req_ExMem = 1; dmem_ready = 0; branch_taken_Ex = 1; settle();
      chk("wait_freeze", 32'(strobes()), 32'b1111010);
      tick();
    end
    dmem_ready = 1; settle();
    chk("wait_done_flush", 32'(strobes()), 32'b0000101);
    tick(); idle(); settle();
    chk("wait_stall_cnt", 32'(stall_cycles), 32'd5);
    chk("wait_flush_cnt", 32'(flush_count), 32'd2);
    chk("wait_no_timeout", 32'(mem_timeout), 32'd0);

    // ready arriving on the timeout-compare cycle completes the access
    dmem_req_ExMem = 1;
    for (int i = 0; i < 256; i++) tick();
    dmem_ready = 1; settle();
    chk("to_edge_ready", 32'(strobes()), 32'h0);
    tick(); idle(); settle();
    chk("to_edge_no_error", 32'(mem_timeout), 32'd0);
    chk("to_edge_idle", 32'(strobes()), 32'h0);
    chk("to_edge_stall_cnt", 32'(stall_cycles), 32'd261);

    // 5: TIMEOUT+2 waiting cycles -> sticky error
    dmem_req_ExMem = 1;
    for (int i = 0; i < 256; i++) tick();
    settle();
    chk("to_not_yet", 32'(mem_timeout), 32'd0);
    tick(); idle(); settle();
    chk("to_set", 32'(mem_timeout), 32'd1);
    chk("to_freeze_held", 32'(strobes()), 32'b1111010);
    branch_taken_Ex = 1; settle();
    chk("to_branch_masked", 32'(strobes()), 32'b1111010);
    idle(); dmem_req_ExMem = 1; dmem_ready = 1; settle();
    chk("to_ready_ignored", 32'(strobes()), 32'b1111010);
    idle();

    // 6: error freeze stalls every cycle; counter pins at all-ones
    for (int i = 0; i < 65400; i++) tick();
    settle();
    chk("sat_stall_cnt", 32'(stall_cycles), 32'hFFFF);
    tick(); tick(); settle();
    chk("sat_stall_hold", 32'(stall_cycles), 32'hFFFF);
    chk("sat_timeout_sticky", 32'(mem_timeout), 32'd1);

    // reset out of ERROR
    rst = 1'b1; settle();
    chk("err_rst_strobes", 32'(strobes()), 32'h0);
    tick(); rst = 1'b0; settle();
    chk("err_rst_timeout", 32'(mem_timeout), 32'd0);
    chk("err_rst_stall_cnt", 32'(stall_cycles), 32'd0);
    chk("err_rst_flush_cnt", 32'(flush_count), 32'd0);
    chk("err_rst_run", 32'(strobes()), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
